avmm_pipelined_responder: RTL

Avalon-MM pipelined read/write responder that terminates the master side of the slave-to-master clock crossing bridge. Holds a 128 x 32-bit register file addressed by a 9-bit byte address. Returns read data with fixed configurable latency through `readdatavalid`, inserts programmable wait states, and caps outstanding reads. Single clock domain; it sits entirely in the bridge's master clock domain.

---
 rtl/avmm_pipelined_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/avmm_pipelined_responder.sv
// Avalon-MM pipelined responder: 128x32 register file, fixed read latency, wait states, read cap.
// Define AVMM_RESPONDER_EOP_EN to carry endofpacket for reads of word EOP_WORD.

module avmm_pipelined_responder #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_PENDING  = 2,
  parameter int unsigned WAIT_STATES  = 0,
  parameter int unsigned EOP_WORD     = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  address,
  input  logic [3:0]  byteenable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        endofpacket
);

  localparam int unsigned PendW = $clog2(READ_LATENCY + 1);
  localparam logic [3:0] WsMax = 4'(WAIT_STATES);
  localparam logic [PendW-1:0] PendMax = PendW'(MAX_PENDING);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                  state_q;
  logic [3:0]              ws_cnt_q;
  logic [31:0]             mem_q [128];
  logic [READ_LATENCY-1:0] pipe_valid_q;
  logic [31:0]             pipe_data_q [READ_LATENCY];

  logic [6:0]       word;
  logic             req;
  logic             retire;
  logic             rd_blocked;
  logic             rd_acc;
  logic             wr_acc;
  logic [PendW-1:0] pending;
  logic             unused_addr;

  assign word        = address[8:2];
  assign unused_addr = ^address[1:0];
  assign req         = read | write;
  assign retire      = pipe_valid_q[READ_LATENCY-1];

  always_comb begin
    pending = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      pending = pending + PendW'(pipe_valid_q[i]);
    end
  end

  // A retiring stage frees its slot in the same cycle, so a full pipe can still accept.
  assign rd_blocked = read & ~write & (pending == PendMax) & ~retire;

  always_comb begin
    waitrequest = 1'b0;
    if (req) begin
      case (state_q)
        StIdle:  waitrequest = (WsMax != 4'd0) | rd_blocked;
        StWait:  waitrequest = (ws_cnt_q != WsMax) | rd_blocked;
        default: waitrequest = 1'b1;
      endcase
    end
  end

  // Simultaneous read and write is treated as a write only.
  assign rd_acc = read & ~write & ~waitrequest;
  assign wr_acc = write & ~waitrequest;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ws_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req && (WsMax != 4'd0)) begin
            state_q  <= StWait;
            ws_cnt_q <= 4'd1;
          end
        end
        StWait: begin
          if (!req) begin
            state_q  <= StIdle;
            ws_cnt_q <= '0;
          end else if (ws_cnt_q != WsMax) begin
            ws_cnt_q <= ws_cnt_q + 4'd1;
          end else if (!waitrequest) begin
            state_q  <= StIdle;
            ws_cnt_q <= '0;
          end
        end
        default: begin
          state_q  <= StIdle;
          ws_cnt_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) begin
          mem_q[word][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_valid_q[0] <= rd_acc;
      pipe_data_q[0]  <= rd_acc ? mem_q[word] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
    end
  end

  assign readdata      = pipe_data_q[READ_LATENCY-1];
  assign readdatavalid = pipe_valid_q[READ_LATENCY-1];

`ifdef AVMM_RESPONDER_EOP_EN
  logic [READ_LATENCY-1:0] pipe_eop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_eop_q <= '0;
    end else begin
      pipe_eop_q[0] <= rd_acc & (word == 7'(EOP_WORD));
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_eop_q[i] <= pipe_eop_q[i-1];
      end
    end
  end

  assign endofpacket = pipe_eop_q[READ_LATENCY-1];
`else
  logic unused_eop_word;
  assign unused_eop_word = ^32'(EOP_WORD);
  assign endofpacket     = 1'b0;
`endif

endmodule
